bpsk_burst_modulator: RTL

Parametrised BPSK transmit core that replaces the fixed, free-running modulator path between the Hamming encoder and the channel. It accepts encoded codewords through a valid/ready handshake and buffers them in an internal FIFO. Each burst starts with a preamble, after which codeword bits are sent MSB first as ±carrier samples. Bit period, codeword width, buffer depth and preamble are all parametrised. The carrier comes from an external sine ROM addressed by this block's phase output.

---
 rtl/bpsk_burst_modulator_if.sv | 11 +
 rtl/bpsk_burst_modulator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bpsk_burst_modulator_if.sv
// Codeword handshake between the encoder (master) and the BPSK burst modulator (slave).
interface bpsk_burst_modulator_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/bpsk_burst_modulator.sv
// Burst BPSK transmitter: FIFO-buffered codewords go out as an alternating preamble
// followed by MSB-first bits, each bit mapped to +/- the external sine ROM sample.
module bpsk_burst_modulator #(
  parameter int DATA_WIDTH      = 12,
  parameter int SAMPLE_WIDTH    = 12,
  parameter int SAMPLES_PER_BIT = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int PREAMBLE_BITS   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  bpsk_burst_modulator_if.slave              s_if,
  output logic [$clog2(SAMPLES_PER_BIT)-1:0] phase_out,
  input  logic signed [SAMPLE_WIDTH-1:0]     sine_in,
  output logic signed [SAMPLE_WIDTH-1:0]     sample_out,
  output logic                               sample_valid,
  output logic                               tx_bit,
  output logic                               burst_start,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  localparam int PH_W     = $clog2(SAMPLES_PER_BIT);
  localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int MAX_BITS = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int IDX_W    = $clog2(MAX_BITS + 1);
  localparam logic signed [SAMPLE_WIDTH-1:0] SMP_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] SMP_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} state_t;

  // Negating the most negative sample would wrap back onto itself, so clamp it.
  function automatic logic signed [SAMPLE_WIDTH-1:0] neg_sat(input logic signed [SAMPLE_WIDTH-1:0] x);
    return (x == SMP_MIN) ? SMP_MAX : -x;
  endfunction

  function automatic logic signed [SAMPLE_WIDTH-1:0] bpsk_map(input logic b,
                                                              input logic signed [SAMPLE_WIDTH-1:0] x);
    return b ? x : neg_sat(x);
  endfunction

  logic [DATA_WIDTH-1:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [LVL_W-1:0]               r_level;
  state_t                         r_state;
  logic [PH_W-1:0]                r_phase_p0;
  logic [IDX_W-1:0]               r_bit_idx;
  logic [DATA_WIDTH-1:0]          r_shift;
  logic signed [SAMPLE_WIDTH-1:0] r_sample_p1;
  logic                           r_vld_p1;
  logic                           r_txbit_p1;
  logic                           r_start_p1;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_nempty;
  logic                  w_last_phase;
  logic                  w_last_pre;
  logic                  w_last_dat;
  logic                  w_cur_bit;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_ready      = (r_level != LVL_W'(FIFO_DEPTH));
  assign w_push       = s_if.s_valid && w_ready;
  assign w_nempty     = (r_level != '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_last_phase = (r_phase_p0 == PH_W'(SAMPLES_PER_BIT - 1));
  assign w_last_pre   = (r_bit_idx == IDX_W'(PREAMBLE_BITS - 1));
  assign w_last_dat   = (r_bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign w_pop        = w_last_phase && (((r_state == S_PREAMBLE) && w_last_pre) ||
                                         ((r_state == S_DATA) && w_last_dat && w_nempty));
  assign w_cur_bit    = (r_state == S_PREAMBLE) ? ~r_bit_idx[0] : r_shift[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_if.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  // Stage p0: burst sequencing, phase counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase_p0 <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_phase_p0 <= '0;
          r_bit_idx  <= '0;
          if (w_nempty) r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          r_phase_p0 <= r_phase_p0 + PH_W'(1);
          if (w_last_phase) begin
            if (w_last_pre) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
              r_shift   <= w_head;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        S_DATA: begin
          r_phase_p0 <= r_phase_p0 + PH_W'(1);
          if (w_last_phase) begin
            if (!w_last_dat) begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end else begin
              r_bit_idx <= '0;
              if (w_nempty) r_shift <= w_head;
              else          r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: symbol mapping against the ROM sample for the p0 phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_txbit_p1  <= 1'b0;
      r_start_p1  <= 1'b0;
      r_sample_p1 <= '0;
    end else begin
      r_vld_p1    <= (r_state != S_IDLE);
      r_txbit_p1  <= (r_state != S_IDLE) && w_cur_bit;
      r_start_p1  <= (r_state == S_PREAMBLE) && (r_bit_idx == '0) && (r_phase_p0 == '0);
      r_sample_p1 <= (r_state == S_IDLE) ? '0 : bpsk_map(w_cur_bit, sine_in);
    end
  end

  assign s_if.s_ready = w_ready;
  assign phase_out    = r_phase_p0;
  assign busy         = (r_state != S_IDLE);
  assign fifo_level   = r_level;
  assign sample_out   = r_sample_p1;
  assign sample_valid = r_vld_p1;
  assign tx_bit       = r_txbit_p1;
  assign burst_start  = r_start_p1;
endmodule
